// File: rtl/rib_rr_arbiter_pkg.sv
// Shared constants and types for the RIB master arbiter and its round-robin picker.
package rib_rr_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned LOCK_CNT_W  = 8;

  localparam logic [IDX_W-1:0] M_CORE_EX = 2'd0;
  localparam logic [IDX_W-1:0] M_CORE_PC = 2'd1;
  localparam logic [IDX_W-1:0] M_JTAG    = 2'd2;
  localparam logic [IDX_W-1:0] M_UART    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Binary index of a one-hot master vector; zero for an all-zero vector.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rib_rr_arbiter_pick4.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping mod 4.
module rr_pick4
  import rib_rr_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] win_c_o,
  output logic                   valid_c_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win_c_o   = '0;
    valid_c_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = ptr_i + IDX_W'(k);
      if (!valid_c_o && req_i[idx]) begin
        win_c_o[idx] = 1'b1;
        valid_c_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin owner arbiter for the four RIB masters with bounded locked ownership.
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [NUM_MASTERS-1:0] lock_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]       sel_o,
  output logic                   busy_o,
  output logic [NUM_MASTERS-1:0] hold_o,
  output logic                   timeout_o
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;

  logic                    owner_req, owner_lock, lock_full, arb_en;
  logic [NUM_MASTERS-1:0]  pick_req, pick_win;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;

  assign owner_req  = req_i[sel_q];
  assign owner_lock = lock_i[sel_q];
  assign lock_full  = (lock_cnt_q == MAX_LOCK_C);
  assign arb_en     = (state_q == ST_IDLE) || !owner_req || !owner_lock || lock_full;

  // The releasing owner never wins its own handover.
  assign pick_req = (state_q == ST_OWN) ? (req_i & ~grant_q) : req_i;
  assign pick_idx = onehot_to_idx(pick_win);

  rr_pick4 u_pick (
    .req_i     (pick_req),
    .ptr_i     (ptr_q),
    .win_c_o   (pick_win),
    .valid_c_o (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    if (arb_en) begin
      timeout_d = (state_q == ST_OWN) && owner_req && owner_lock && lock_full;
      if (pick_valid) begin
        state_d    = ST_OWN;
        grant_d    = pick_win;
        sel_d      = pick_idx;
        ptr_d      = pick_idx + IDX_W'(1);
        lock_cnt_d = LOCK_CNT_W'(1);
        busy_d     = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        sel_d      = M_CORE_EX;
        lock_cnt_d = '0;
        busy_d     = 1'b0;
      end
    end else if (lock_cnt_q < MAX_LOCK_C) begin
      lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      grant_q    <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;
  assign hold_o    = req_i & ~grant_q;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Scoreboarded bench for rib_rr_arbiter: per-cycle expected outputs queued at drive time.
module tb_rib_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i, lock_i, grant_o, hold_o;
  logic [1:0] sel_o;
  logic       busy_o, timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    logic [3:0] hold;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic       timeout;
  } row_t;

  obs_t exp_q[$];

  rib_rr_arbiter #(.MAX_LOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .grant_o   (grant_o),
    .sel_o     (sel_o),
    .busy_o    (busy_o),
    .hold_o    (hold_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t row(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                               input logic [3:0] g, input logic to);
    row_t x;
    x.rst = r; x.req = rq; x.lock = lk; x.grant = g; x.timeout = to;
    return x;
  endfunction

  function automatic obs_t mk_exp(input logic [3:0] g, input logic to, input logic [3:0] rq);
    obs_t e;
    e.grant   = g;
    e.sel     = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    e.busy    = (g != 4'b0000);
    e.timeout = to;
    e.hold    = rq & ~g;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_i = '0; lock_i = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t tab [2];
    obs_t e, o;
    tab = '{row(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0),
            row(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = tab[i].rst; req_i = tab[i].req; lock_i = tab[i].lock;
      exp_q.push_back(mk_exp(tab[i].grant, tab[i].timeout, tab[i].req));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {grant_o, sel_o, busy_o, timeout_o, hold_o};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset row %0d: got %b want %b (grant,sel,busy,timeout,hold)", i, o, e);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t tab [6];
    obs_t e, o;
    tab = '{row(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0),
            row(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0),
            row(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0),
            row(1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0),
            row(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0),
            row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = tab[i].rst; req_i = tab[i].req; lock_i = tab[i].lock;
      exp_q.push_back(mk_exp(tab[i].grant, tab[i].timeout, tab[i].req));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {grant_o, sel_o, busy_o, timeout_o, hold_o};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL round_robin row %0d: got %b want %b (grant,sel,busy,timeout,hold)", i, o, e);
      end
    end
  endtask

  task automatic test_lock_timeout();
    row_t tab [7];
    obs_t e, o;
    tab = '{row(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0),
            row(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0),
            row(1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b0),
            row(1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b0),
            row(1'b0, 4'b0101, 4'b0100, 4'b0001, 1'b1),
            row(1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b0),
            row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = tab[i].rst; req_i = tab[i].req; lock_i = tab[i].lock;
      exp_q.push_back(mk_exp(tab[i].grant, tab[i].timeout, tab[i].req));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {grant_o, sel_o, busy_o, timeout_o, hold_o};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lock_timeout row %0d: got %b want %b (grant,sel,busy,timeout,hold)", i, o, e);
      end
    end
  endtask

  task automatic test_drop_handover();
    row_t tab [5];
    obs_t e, o;
    tab = '{row(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0),
            row(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0),
            row(1'b0, 4'b1010, 4'b1000, 4'b1000, 1'b0),
            row(1'b0, 4'b0010, 4'b1000, 4'b0010, 1'b0),
            row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = tab[i].rst; req_i = tab[i].req; lock_i = tab[i].lock;
      exp_q.push_back(mk_exp(tab[i].grant, tab[i].timeout, tab[i].req));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {grant_o, sel_o, busy_o, timeout_o, hold_o};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL drop_handover row %0d: got %b want %b (grant,sel,busy,timeout,hold)", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    row_t tab [6];
    obs_t e, o;
    tab = '{row(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0),
            row(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0),
            row(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0),
            row(1'b0, 4'b1100, 4'b0000, 4'b0100, 1'b0),
            row(1'b0, 4'b1100, 4'b0000, 4'b1000, 1'b0),
            row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = tab[i].rst; req_i = tab[i].req; lock_i = tab[i].lock;
      exp_q.push_back(mk_exp(tab[i].grant, tab[i].timeout, tab[i].req));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {grant_o, sel_o, busy_o, timeout_o, hold_o};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_lock row %0d: got %b want %b (grant,sel,busy,timeout,hold)", i, o, e);
      end
      if (tab[i].rst) begin
        n_checks++;
        if (dut.ptr_q !== 2'd0 || dut.lock_cnt_q !== 8'd0) begin
          n_fail++;
          $display("FAIL reset_mid_lock internals: got ptr=%0d lock_cnt=%0d want ptr=0 lock_cnt=0",
                   dut.ptr_q, dut.lock_cnt_q);
        end
      end
    end
  endtask

  task automatic test_lone_unlocked();
    row_t tab [9];
    obs_t e, o;
    for (int i = 0; i < 8; i++)
      tab[i] = row(1'b0, 4'b0010, 4'b0000, (i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
    tab[8] = row(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = tab[i].rst; req_i = tab[i].req; lock_i = tab[i].lock;
      exp_q.push_back(mk_exp(tab[i].grant, tab[i].timeout, tab[i].req));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {grant_o, sel_o, busy_o, timeout_o, hold_o};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lone_unlocked row %0d: got %b want %b (grant,sel,busy,timeout,hold)", i, o, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_i = '0; lock_i = '0;
    test_reset();
    test_round_robin();
    test_lock_timeout();
    test_drop_handover();
    test_reset_mid_lock();
    test_lone_unlocked();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rib_rr_arbiter.md
# rib_rr_arbiter

Round-robin arbiter for the four RIB bus masters: core data port (m0), core fetch port (m1), JTAG memory port (m2) and UART download port (m3). It grants the shared RIB to one master at a time and gives fair access in rotation. It supports locked multi-beat ownership with a bounded timeout, and produces per-master hold signals so the core pipeline stalls while it is not granted. It sits between the master request lines and the RIB address/data mux select.

## Interface
- MAX_LOCK, 16: maximum consecutive grant cycles for a locked owner; legal range 1..255.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_i  in  4  per-master request, held high until served
- lock_i  in  4  per-master lock; owner keeps the grant while its req and lock are high
- grant_o  out  4  one-hot grant, registered; all zero when no master owns the bus
- sel_o  out  2  binary index of the owner, registered; 0 when idle
- busy_o  out  1  |grant_o
- hold_o  out  4  req_i & ~grant_o, combinational; bit 0 drives the core stall
- timeout_o  out  1  one-cycle pulse when a lock is forcibly ended

## Operation
- Two states:
  - IDLE: no owner.
  - OWN: one owner; its grant_o bit is high.
- Round-robin pointer ptr (2 bits): the search for the next owner starts at index ptr and ascends modulo 4. When master i is granted, ptr becomes (i+1) mod 4.
- Arbitration runs at every edge where the state is IDLE, or the state is OWN and the owner releases.
- Owner release happens at an edge if any of these holds:
  - req_i[owner] is low;
  - lock_i[owner] is low (single-beat grant);
  - lock_cnt has reached MAX_LOCK.
- At a release edge, the next winner is chosen from req_i with the owner's bit masked off. If another master is requesting, ownership passes directly to it with no idle cycle. If no other master is requesting, the state becomes IDLE.
- Since the owner's bit is masked at release, a single lone requester with lock low gets grant high and low on alternating cycles (one beat every 2 cycles).
- lock_cnt counts grant cycles of the current owner:
  - set to 1 on each new grant;
  - incremented each held cycle;
  - saturates at MAX_LOCK;
  - width is 8 bits.
- Forced release: timeout_o pulses in the cycle after the edge at which lock_cnt == MAX_LOCK and the owner still had req and lock high. ptr advances normally.
- A change of lock_i mid-grant takes effect at the next edge.
- A master that drops req while not granted is simply skipped.
- Reset:
  - state IDLE, ptr 0, lock_cnt 0;
  - grant_o 0, sel_o 0, timeout_o 0;
  - busy_o 0; hold_o equals req_i.
  - Reset asserted mid-ownership ends the grant at that edge with no timeout pulse.

## Timing
- Grant latency: a req sampled high at edge N while IDLE gives a grant in cycle N+1.
- Handover: an owner releasing at edge N and the new owner granted at N+1 means zero idle cycles.
- An unlocked grant lasts exactly 1 cycle. A locked grant lasts at most MAX_LOCK cycles.
- Worst-case wait for a requester: 3·MAX_LOCK cycles.
- grant_o, sel_o and timeout_o change only on clk edges. hold_o follows req_i combinationally within the cycle.
- Simultaneous requests at the same edge are resolved by ptr order only. There is no fixed priority.

## Structure
- Shared package/defines: the master index constants (M_CORE_EX=0, M_CORE_PC=1, M_JTAG=2, M_UART=3) and the master count 4.
- One sub-module, rr_pick4: a combinational round-robin picker. Inputs: a 4-bit request mask and a 2-bit start pointer. Outputs: a one-hot winner and a valid flag. It is reusable for the slave-side interrupt arbitration.
- The top holds the state register, ptr, lock_cnt and output registers.

## Test plan
- Reset with req_i=4'b1111 → grant_o=0, hold_o=4'b1111. First edge after reset release → grant_o=4'b0001, sel_o=0.
- req_i=4'b1111, lock_i=0 held → grants cycle 0001,0010,0100,1000,0001 on consecutive cycles with no gaps.
- req_i=4'b0100 lock_i=4'b0100 with MAX_LOCK=4, req_i[0] raised at cycle 2 → m2 granted for 4 cycles, timeout_o pulses once, then grant_o=0001.
- m3 owns with lock, m3 drops req at edge N while m1 requests → grant_o=0010 in cycle N+1, timeout_o stays 0.
- rst asserted while m2 holds a locked grant → grant_o=0 in the next cycle, ptr=0, lock_cnt=0. After release with req_i=4'b1100 → m2 is granted first.
- Lone requester m1 with lock low held for 8 cycles → grant_o toggles 0010/0000; hold_o[1] equals the inverse of grant_o[1].
